// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Per-register write scoreboard for the decode stage. Each architectural
// register r (1..NUM_REGS-1) has a small down-counter holding the number of
// cycles until its in-flight write reaches the register file. Decode stalls on
// read-after-write and write-after-write hazards against those counters, and
// the number of stalled cycles is counted (saturating).
//
// Optional feature macro: HAZARD_SCOREBOARD_FWD_EN
//   defined   : operands whose writer retires next cycle (cnt == 1) are taken
//               from the writeback bypass instead of stalling; fwd_rs1_o and
//               fwd_rs2_o are present.
//   undefined : operands are read from the register file only; any pending
//               write to a source stalls; no fwd_* ports.
//
// Ports
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   id_valid_i      ID holds a real instruction (0 = bubble)
//   id_rs1_i        source register 1
//   id_rs2_i        source register 2
//   id_rs1_used_i   rs1 is a true operand
//   id_rs2_used_i   rs2 is a true operand
//   id_rd_i         destination register
//   id_reg_write_i  instruction writes rd
//   id_lat_i        cycles from issue until the result reaches the regfile
//   flush_i         squash ID this cycle
//   hazard_o        stall ID / insert NOP
//   issue_o         instruction leaves ID this cycle
//   busy_o          any write still pending
//   stall_cnt_o     saturating count of cycles with hazard_o = 1
//   fwd_rs1_o       (FWD_EN only) rs1 taken from the bypass
//   fwd_rs2_o       (FWD_EN only) rs2 taken from the bypass
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_LAT  = 4,
  parameter int CW       = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic [CW-1:0]     id_lat_i,
  input  logic              flush_i,
  output logic              hazard_o,
  output logic              issue_o,
  output logic              busy_o,
  output logic [15:0]       stall_cnt_o
`ifdef HAZARD_SCOREBOARD_FWD_EN
  ,
  output logic              fwd_rs1_o,
  output logic              fwd_rs2_o
`endif
);

  localparam logic [CW-1:0] LAT_ONE = CW'(1);
  localparam logic [CW-1:0] LAT_MAX = CW'(MAX_LAT);

  // With the bypass, a writer retiring next cycle no longer blocks a reader.
`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam logic [CW-1:0] RAW_T = CW'(1);
`else
  localparam logic [CW-1:0] RAW_T = CW'(0);
`endif

  // x0 has no entry at all, so it can never be marked pending.
  logic [CW-1:0] cnt_q [1:NUM_REGS-1];

  logic [CW-1:0] rs1_cnt;
  logic [CW-1:0] rs2_cnt;
  logic [CW-1:0] rd_cnt;
  logic          rd_tracked;
  logic [CW-1:0] lat_eff;
  logic          raw_rs1;
  logic          raw_rs2;
  logic          waw;
  logic          rd_alloc;

  // Counter lookup for the three register fields. Indices 0 and >= NUM_REGS
  // match no entry and read as 0, which makes them hazard-free for free.
  always_comb begin
    rs1_cnt    = '0;
    rs2_cnt    = '0;
    rd_cnt     = '0;
    rd_tracked = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (id_rs1_i == REG_AW'(r)) rs1_cnt = cnt_q[r];
      if (id_rs2_i == REG_AW'(r)) rs2_cnt = cnt_q[r];
      if (id_rd_i == REG_AW'(r)) begin
        rd_cnt     = cnt_q[r];
        rd_tracked = 1'b1;
      end
    end
  end

  // Effective latency: 0 behaves like 1, anything above MAX_LAT is clamped.
  always_comb begin
    if (id_lat_i == '0)          lat_eff = LAT_ONE;
    else if (id_lat_i > LAT_MAX) lat_eff = LAT_MAX;
    else                         lat_eff = id_lat_i;
  end

  // Hazard detection uses pre-update counters, so an instruction reading its
  // own rd (addi x5,x5,1) never stalls on itself. WAW stalls only while the
  // older write would land after this younger one.
  always_comb begin
    raw_rs1  = id_rs1_used_i & (rs1_cnt > RAW_T);
    raw_rs2  = id_rs2_used_i & (rs2_cnt > RAW_T);
    waw      = id_reg_write_i & (rd_cnt > lat_eff);
    hazard_o = id_valid_i & ~flush_i & (raw_rs1 | raw_rs2 | waw);
    issue_o  = id_valid_i & ~hazard_o & ~flush_i;
    rd_alloc = issue_o & id_reg_write_i & rd_tracked;
  end

  // Any pending write keeps the scoreboard busy.
  always_comb begin
    busy_o = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_o = busy_o | (cnt_q[r] != '0);
    end
  end

`ifdef HAZARD_SCOREBOARD_FWD_EN
  // A count of exactly 1 means the value is on the writeback bus this cycle.
  always_comb begin
    fwd_rs1_o = issue_o & id_rs1_used_i & (rs1_cnt == LAT_ONE);
    fwd_rs2_o = issue_o & id_rs2_used_i & (rs2_cnt == LAT_ONE);
  end
`endif

  // Counters tick down every cycle, flush or not, since the writes belong to
  // older instructions. A newly issued writer reloads its own entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (rd_alloc && (id_rd_i == REG_AW'(r))) begin
          cnt_q[r] <= lat_eff;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - LAT_ONE;
        end
      end
    end
  end

  // Stall cycle counter, sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= 16'd0;
    end else if (hazard_o && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule
